wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clk and reset; reset is synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous active-high reset
 in_valid  in  1  upstream (MEM stage) instruction valid
 in_ready  out  1  block can accept an instruction this cycle
 in_rd  in  5  destination register
 in_result  in  32  ALU result; for loads, the byte address
 in_is_load  in  1  instruction is a load
 in_mem_op  in  3  load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
 in_wb_en  in  1  instruction writes rd
 dmem_rvalid  in  1  data-memory read data valid
 dmem_rdata  in  32  data-memory aligned word
 wb_rd  out  5  register-file write index (to ID)
 wb_data  out  32  register-file write data (to ID)
 wb_enable  out  1  register-file write strobe, one cycle per write
 load_err  out  1  one-cycle pulse on misaligned or illegal load
 retired  out  32  count of instructions retired

Function
REQ-003 The state machine SHALL have two states: IDLE and WAIT_MEM.
REQ-004 in_ready SHALL be 1 in IDLE and 0 in WAIT_MEM; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-005 On a non-load transfer at edge N, the block SHALL drive wb_rd=in_rd, wb_data=in_result and wb_enable=(in_wb_en and in_rd!=0) during the cycle after edge N, and stay in IDLE.
REQ-006 Back-to-back non-load transfers SHALL sustain one write per cycle.
REQ-007 On a load transfer, the block SHALL latch rd, mem_op, addr[1:0] and wb_en, then enter WAIT_MEM.
REQ-008 In WAIT_MEM, on the first edge with dmem_rvalid=1, the block SHALL drive the extracted load value with wb_enable for one cycle, then return to IDLE.
REQ-009 dmem_rvalid SHALL be ignored in IDLE, including in the same cycle as a load transfer; the earliest accepted response is at edge N+1.
REQ-010 Load extraction SHALL work as follows:
 - LB/LBU select byte addr[1:0] (byte 0 = bits 7:0), sign- or zero-extended to 32 bits.
 - LH/LHU select half addr[1] (half 0 = bits 15:0), sign- or zero-extended to 32 bits.
 - LW passes the word unchanged.
REQ-011 Misaligned loads (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) and reserved mem_op values (011, 110, 111) SHALL complete the handshake normally, suppress wb_enable, and pulse load_err in the write cycle.
REQ-012 wb_enable SHALL be 0 whenever rd==0 or wb_en==0, and in every cycle with no completing instruction.
REQ-013 wb_rd and wb_data SHALL hold their last values when wb_enable is 0.
REQ-014 retired SHALL increment by 1 in every write cycle of a completing instruction, whether or not it writes. This includes rd==0, wb_en==0 and load_err cases. The counter SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 All outputs except in_ready SHALL be registered.

Reset
REQ-016 When reset=1 at a rising edge, the block SHALL set state=IDLE, wb_rd=0, wb_data=0, wb_enable=0, load_err=0 and retired=0; in_ready SHALL be 0 while reset is high.
REQ-017 Reset during WAIT_MEM SHALL abandon the pending load with no write, and a dmem_rvalid arriving after reset SHALL be ignored.

Structure
REQ-018 Load funct3 codes and state encodings SHALL be constants in the shared rv32_defs package, used by both decode and writeback.
REQ-019 Byte/half selection and extension SHALL be one combinational sub-module, load_align (inputs: mem_op, addr[1:0], word; outputs: data, err).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
 - Non-load rd=5, result=0x12345678, wb_en=1 -> next cycle wb_enable=1, wb_rd=5, wb_data=0x12345678; retired=1.
 - Three consecutive non-loads (rd 1, 2, 3) -> wb_enable high three consecutive cycles; in_ready stays 1.
 - LB addr=0x...3, rdata=0x80FF0011 with rvalid 3 cycles later -> in_ready low for 3 cycles; wb_data=0xFFFFFF80. Same case with LBU -> 0x00000080.
 - LH addr=0x...1 -> load_err pulse, wb_enable=0, retired increments. Non-load with rd=0 -> wb_enable=0, retired increments.
 - Load accepted, reset asserted in WAIT_MEM, then rvalid=1 -> no write; retired=0; state IDLE.
 - retired preset to 0xFFFFFFFF via forced sequence, one more retire -> retired=0.

Source files
------------

// File: rtl/rv32_defs.sv
// rtl/rv32_defs.sv - shared RV32 load funct3 codes and writeback state encodings
package rv32_defs;

  // Load funct3 codes, shared by decode and writeback
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback stage states: accepting instructions, or parked on a load response
  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - byte/half/word selection and extension of a loaded word
module load_align
  import rv32_defs::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        err
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Move the addressed byte down to bit 0; the half is picked by addr[1]
  always_comb begin
    shifted  = word >> {addr, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  // Extend per funct3; misaligned halves/words and reserved codes flag err
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mem_op)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'h000000, byte_sel};
      F3_LH: begin
        data = {{16{half_sel[15]}}, half_sel};
        err  = addr[0];
      end
      F3_LHU: begin
        data = {16'h0000, half_sel};
        err  = addr[0];
      end
      F3_LW: begin
        data = word;
        err  = (addr != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32 writeback stage with blocking load completion
module wb_stage
  import rv32_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_mem_op,
  input  logic        in_wb_en,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_enable,
  output logic        load_err,
  output logic [31:0] retired
);

  wb_state_e   state_q, state_d;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_op_q;
  logic [1:0]  ld_addr_q;
  logic        ld_wb_en_q;
  logic        capture;

  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_enable_q, wb_enable_d;
  logic        load_err_q, load_err_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] ld_data;
  logic        ld_err;

  load_align u_load_align (
    .mem_op (ld_op_q),
    .addr   (ld_addr_q),
    .word   (dmem_rdata),
    .data   (ld_data),
    .err    (ld_err)
  );

  // Ready only when idle and out of reset
  always_comb begin
    in_ready = (state_q == WB_IDLE) && !reset;
  end

  // Next state and registered-output values for the coming edge
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_enable_d = 1'b0;
    load_err_d  = 1'b0;
    retired_d   = retired_q;
    case (state_q)
      WB_IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            capture = 1'b1;
            state_d = WB_WAIT_MEM;
          end else begin
            retired_d = retired_q + 32'd1;
            if (in_wb_en && (in_rd != 5'd0)) begin
              wb_enable_d = 1'b1;
              wb_rd_d     = in_rd;
              wb_data_d   = in_result;
            end
          end
        end
      end
      WB_WAIT_MEM: begin
        if (dmem_rvalid) begin
          state_d    = WB_IDLE;
          retired_d  = retired_q + 32'd1;
          load_err_d = ld_err;
          if (!ld_err && ld_wb_en_q && (ld_rd_q != 5'd0)) begin
            wb_enable_d = 1'b1;
            wb_rd_d     = ld_rd_q;
            wb_data_d   = ld_data;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State, pending-load fields and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      ld_rd_q     <= '0;
      ld_op_q     <= '0;
      ld_addr_q   <= '0;
      ld_wb_en_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_enable_q <= 1'b0;
      load_err_q  <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_enable_q <= wb_enable_d;
      load_err_q  <= load_err_d;
      retired_q   <= retired_d;
      if (capture) begin
        ld_rd_q    <= in_rd;
        ld_op_q    <= in_mem_op;
        ld_addr_q  <= in_result[1:0];
        ld_wb_en_q <= in_wb_en;
      end
    end
  end

  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_enable = wb_enable_q;
  assign load_err  = load_err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a behavioural model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_mem_op;
  logic        in_wb_en;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_enable;
  logic        load_err;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: instruction-level view of the stage
  bit          m_pend = 1'b0;
  logic [4:0]  m_prd;
  logic [2:0]  m_pop;
  logic [1:0]  m_paddr;
  bit          m_pwen;
  logic [4:0]  e_rd = '0;
  logic [31:0] e_data = '0;
  bit          e_en = 1'b0;
  bit          e_err = 1'b0;
  logic [31:0] e_ret = '0;

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_result   (in_result),
    .in_is_load  (in_is_load),
    .in_mem_op   (in_mem_op),
    .in_wb_en    (in_wb_en),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_enable   (wb_enable),
    .load_err    (load_err),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load value from the word using plain shifts and arithmetic
  function automatic void extract(input logic [2:0] op, input logic [1:0] a,
                                  input logic [31:0] w, output logic [31:0] v, output bit bad);
    int unsigned bv, hv;
    int sv;
    bv  = (w >> (8 * int'(a))) & 32'hFF;
    hv  = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
    v   = w;
    bad = 1'b0;
    case (op)
      3'd0: begin sv = (bv >= 128) ? int'(bv) - 256 : int'(bv); v = sv; end
      3'd4: v = bv;
      3'd1: begin sv = (hv >= 32768) ? int'(hv) - 65536 : int'(hv); v = sv; bad = (a % 2) != 0; end
      3'd5: begin v = hv; bad = (a % 2) != 0; end
      3'd2: bad = (a != 0);
      default: bad = 1'b1;
    endcase
  endfunction

  task automatic step(input bit rst, input bit v, input bit ld, input logic [4:0] rd,
                      input logic [31:0] res, input logic [2:0] op, input bit wen,
                      input bit rv, input logic [31:0] rdat);
    logic [31:0] val;
    bit bad;
    reset = rst; in_valid = v; in_is_load = ld; in_rd = rd; in_result = res;
    in_mem_op = op; in_wb_en = wen; dmem_rvalid = rv; dmem_rdata = rdat;
    #1;
    check_eq("in_ready", in_ready, (!rst && !m_pend));
    @(posedge clk);
    e_en = 1'b0;
    e_err = 1'b0;
    if (rst) begin
      m_pend = 1'b0; e_rd = '0; e_data = '0; e_ret = '0;
    end else if (!m_pend) begin
      if (v && ld) begin
        m_pend = 1'b1; m_prd = rd; m_pop = op; m_paddr = res[1:0]; m_pwen = wen;
      end else if (v) begin
        e_ret = e_ret + 1;
        if (wen && rd != 0) begin e_en = 1'b1; e_rd = rd; e_data = res; end
      end
    end else if (rv) begin
      m_pend = 1'b0;
      e_ret = e_ret + 1;
      extract(m_pop, m_paddr, rdat, val, bad);
      e_err = bad;
      if (!bad && m_pwen && m_prd != 0) begin e_en = 1'b1; e_rd = m_prd; e_data = val; end
    end
    #1;
    check_eq("wb_enable", wb_enable, e_en);
    check_eq("load_err", load_err, e_err);
    check_eq("retired", retired, e_ret);
    check_eq("wb_rd", wb_rd, e_rd);
    check_eq("wb_data", wb_data, e_data);
  endtask

  task automatic idle(input bit rv);
    step(0, 0, 0, 0, 0, 0, 0, rv, 32'h80FF0011);
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 7, 32'h1, 0, 1, 1, 0);
    check_eq("rst_retired", retired, 32'h0);

    // single non-load write
    step(0, 1, 0, 5, 32'h12345678, 0, 1, 0, 0);
    check_eq("dir_wb_data", wb_data, 32'h12345678);
    check_eq("dir_wb_rd", wb_rd, 32'd5);
    check_eq("dir_retired1", retired, 32'd1);

    // three back-to-back non-loads
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 5'(i), 32'(i * 16), 0, 1, 0, 0);
      check_eq("b2b_enable", wb_enable, 32'd1);
      check_eq("b2b_ready", in_ready, 32'd1);
    end

    // LB at addr 3, response three cycles later
    step(0, 1, 1, 9, 32'h00001003, 3'b000, 1, 0, 0);
    idle(0); idle(0);
    idle(1);
    check_eq("lb_data", wb_data, 32'hFFFFFF80);
    // LBU, with rvalid asserted alongside the transfer (must be ignored)
    step(0, 1, 1, 9, 32'h00001003, 3'b100, 1, 1, 32'h80FF0011);
    idle(0); idle(0);
    idle(1);
    check_eq("lbu_data", wb_data, 32'h00000080);

    // misaligned LH, then non-load to x0
    step(0, 1, 1, 4, 32'h00000001, 3'b001, 1, 0, 0);
    idle(1);
    check_eq("lh_err", load_err, 32'd1);
    step(0, 1, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0);
    check_eq("rd0_enable", wb_enable, 32'd0);

    // reset while waiting for memory
    step(0, 1, 1, 6, 32'h0, 3'b010, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check_eq("abandon_ret", retired, 32'd0);
    check_eq("abandon_en", wb_enable, 32'd0);
    idle(0);
    check_eq("abandon_idle", in_ready, 32'd1);

    // retired wrap
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    e_ret = 32'hFFFFFFFF;
    check_eq("preset_ret", retired, 32'hFFFFFFFF);
    step(0, 1, 0, 3, 32'h5, 0, 0, 0, 0);
    check_eq("wrap_ret", retired, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           5'($urandom), $urandom, 3'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
